usb_bulk_ep_fifo: RTL and testbench

- Endpoint data stage sitting directly downstream/upstream of the USB device controller's user-side data bus (txdat/txval/txcork/txpop/txact/txpktfin, rxdat/rxval/rxrdy/rxact/rxpktval, endpt).
- Implements one bulk IN and one bulk OUT endpoint, each backed by a packet-transactional FIFO: bytes are committed only on a good packet and rolled back on a failed or retried one.
- User logic sees plain byte streams with valid/ready handshakes.

---
 rtl/usb_ep_pkg.sv | 12 +
 rtl/usb_txn_fifo.sv | 48 ++++
 rtl/usb_bulk_ep_fifo.sv | 109 ++++++++++
 tb/tb_usb_bulk_ep_fifo.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared pointer width, FSM state codes and length helper for the bulk endpoint FIFOs
package usb_ep_pkg;
  typedef logic [0:0] state_t;
  localparam state_t IDLE   = 1'b0;
  localparam state_t ACTIVE = 1'b1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int min_len(input int a, input int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/usb_txn_fifo.sv
// usb_txn_fifo: byte FIFO with committed/speculative pointer pairs on both sides
//   wr_i/wr_data_i      write at wr_spec and advance it
//   wr_commit_i         wr_commit <= wr_spec (including a same-cycle write)
//   wr_rollback_i       wr_spec <= wr_commit
//   rd_i                advance rd_spec; rd_data_o shows the byte at rd_spec
//   rd_commit_i         rd_commit <= rd_spec (including a same-cycle read)
//   rd_rollback_i       rd_spec <= rd_commit
//   count_o             wr_commit - rd_commit
//   spec_used_o         wr_spec - rd_commit (space already claimed by an open packet)
module usb_txn_fifo
  import usb_ep_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_commit_i,
  input  logic          wr_rollback_i,
  input  logic          rd_i,
  input  logic          rd_commit_i,
  input  logic          rd_rollback_i,
  output logic [7:0]    rd_data_o,
  output logic [PW-1:0] count_o,
  output logic [PW-1:0] spec_used_o
);
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wr_c, wr_s, rd_c, rd_s, wr_s_n, rd_s_n;
  assign wr_s_n      = wr_s + PW'(wr_i);
  assign rd_s_n      = rd_s + PW'(rd_i);
  assign rd_data_o   = mem[rd_s[PW-2:0]];
  assign count_o     = wr_c - rd_c;
  assign spec_used_o = wr_s - rd_c;
  always_ff @(posedge clk_i)
    if (wr_i) mem[wr_s[PW-2:0]] <= wr_data_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) {wr_c, wr_s, rd_c, rd_s} <= '0;
    else if (clr_i) {wr_c, wr_s, rd_c, rd_s} <= '0;
    else begin
      wr_s <= wr_rollback_i ? wr_c : wr_s_n;
      wr_c <= wr_commit_i ? wr_s_n : wr_c;
      rd_s <= rd_rollback_i ? rd_c : rd_s_n;
      rd_c <= rd_commit_i ? rd_s_n : rd_c;
    end
endmodule

// File: rtl/usb_bulk_ep_fifo.sv
// usb_bulk_ep_fifo: bulk IN/OUT endpoint data stage with packet-transactional FIFOs
//   clk_i/rst_n_i/usbrst_i       clock, async active-low reset, bus-reset flush
//   highspeed_i                  selects max packet size
//   endpt_i/txact_i/txpop_i/txpktfin_i/txdat_o/txval_o/txdat_len_o/txcork_o  controller IN side
//   rxdat_i/rxval_i/rxact_i/rxpktval_i/rxrdy_o                               controller OUT side
//   in_data_i/in_valid_i/in_ready_o, out_data_o/out_valid_o/out_ready_i      user byte streams
//   rx_overflow_o                sticky dropped-OUT-packet flag
module usb_bulk_ep_fifo
  import usb_ep_pkg::*;
#(
  parameter int EP_NUM    = 1,
  parameter int DEPTH     = 1024,
  parameter int HS_MAXPKT = 512,
  parameter int FS_MAXPKT = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        usbrst_i,
  input  logic        highspeed_i,
  input  logic [3:0]  endpt_i,
  input  logic        txact_i,
  input  logic        txpop_i,
  input  logic        txpktfin_i,
  output logic [7:0]  txdat_o,
  output logic        txval_o,
  output logic [11:0] txdat_len_o,
  output logic        txcork_o,
  input  logic [7:0]  rxdat_i,
  input  logic        rxval_i,
  input  logic        rxact_i,
  input  logic        rxpktval_i,
  output logic        rxrdy_o,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        rx_overflow_o
);
  localparam int PW = ptr_w(DEPTH);
  state_t in_st, out_st;
  logic live_q, live, txact_q, rxact_q, bad_q, rxrdy_q, ovf_q;
  logic [11:0] len_q;
  logic [PW-1:0] cnt_in, in_used, cnt_out, used_out, maxpkt;
  logic [7:0] tx_byte;
  logic ep_hit, in_wr, tx_rd, tx_go, tx_cm, tx_rb, out_pop, rx_go, rx_fall, rx_drop, rx_wr, rx_cm, rx_rb;
  // live holds outputs at their reset values for the first cycle after rst_n_i/usbrst_i
  assign live          = live_q & !usbrst_i;
  assign maxpkt        = highspeed_i ? PW'(HS_MAXPKT) : PW'(FS_MAXPKT);
  assign ep_hit        = endpt_i == 4'(EP_NUM);
  // the IN FIFO commits every user write at once, so its speculative usage equals its count
  assign in_ready_o    = live & (in_used != PW'(DEPTH));
  assign txcork_o      = !live | (in_st == IDLE & cnt_in == '0);
  assign txval_o       = !txcork_o;
  assign txdat_o       = txval_o ? tx_byte : 8'h00;
  assign txdat_len_o   = len_q;
  assign out_valid_o   = live & (cnt_out != '0);
  assign rxrdy_o       = rxrdy_q;
  assign rx_overflow_o = ovf_q;
  assign in_wr         = in_valid_i & in_ready_o;
  assign out_pop       = out_valid_o & out_ready_i;
  // IN tokens are only taken with data queued, so no zero-length packet goes out
  assign tx_go   = live & in_st == IDLE & txact_i & !txact_q & ep_hit & cnt_in != '0;
  assign tx_rd   = in_st == ACTIVE & txpop_i;
  assign tx_cm   = in_st == ACTIVE & txpktfin_i;
  assign tx_rb   = in_st == ACTIVE & !txact_i & txact_q & !txpktfin_i;
  assign rx_go   = live & out_st == IDLE & rxact_i & !rxact_q & ep_hit;
  assign rx_fall = out_st == ACTIVE & !rxact_i & rxact_q;
  assign rx_drop = out_st == ACTIVE & rxval_i & used_out == PW'(DEPTH);
  assign rx_wr   = out_st == ACTIVE & rxval_i & !rx_drop;
  assign rx_cm   = out_st == ACTIVE & rxpktval_i & !bad_q & !rx_drop;
  // a commit and a falling rxact_i in the same cycle must not also roll back
  assign rx_rb   = rx_fall & !rx_cm;
  usb_txn_fifo #(.DEPTH(DEPTH)) u_in (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(usbrst_i),
    .wr_i(in_wr), .wr_data_i(in_data_i), .wr_commit_i(1'b1), .wr_rollback_i(1'b0),
    .rd_i(tx_rd), .rd_commit_i(tx_cm), .rd_rollback_i(tx_go | tx_rb),
    .rd_data_o(tx_byte), .count_o(cnt_in), .spec_used_o(in_used)
  );
  usb_txn_fifo #(.DEPTH(DEPTH)) u_out (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(usbrst_i),
    .wr_i(rx_wr), .wr_data_i(rxdat_i), .wr_commit_i(rx_cm), .wr_rollback_i(rx_go | rx_rb),
    .rd_i(out_pop), .rd_commit_i(1'b1), .rd_rollback_i(1'b0),
    .rd_data_o(out_data_o), .count_o(cnt_out), .spec_used_o(used_out)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      {live_q, txact_q, rxact_q, bad_q, rxrdy_q, ovf_q} <= '0;
      in_st  <= IDLE;
      out_st <= IDLE;
      len_q  <= '0;
    end else if (usbrst_i) begin
      {live_q, txact_q, rxact_q, bad_q, rxrdy_q, ovf_q} <= '0;
      in_st  <= IDLE;
      out_st <= IDLE;
      len_q  <= '0;
    end else begin
      live_q  <= 1'b1;
      txact_q <= txact_i;
      rxact_q <= rxact_i;
      in_st   <= tx_go ? ACTIVE : (tx_cm | tx_rb) ? IDLE : in_st;
      len_q   <= tx_go ? 12'(min_len(int'(cnt_in), int'(maxpkt))) : len_q;
      out_st  <= rx_go ? ACTIVE : rx_fall ? IDLE : out_st;
      bad_q   <= rx_go ? 1'b0 : bad_q | rx_drop;
      ovf_q   <= ovf_q | (rx_rb & bad_q);
      rxrdy_q <= out_st == IDLE ? (PW'(DEPTH) - cnt_out) >= maxpkt : rxrdy_q;
    end
endmodule

// File: tb/tb_usb_bulk_ep_fifo.sv
// tb_usb_bulk_ep_fifo: vector table, directed corner sequences and random traffic against a queue model
module tb_usb_bulk_ep_fifo;
  localparam int DEPTH = 1024;
  typedef logic [7:0] bq_t [$];
  typedef struct { bit hs; int n; int ep; int len; bit cork; } vec_t;
  logic clk_i = 0, rst_n_i = 1, usbrst_i = 0, highspeed_i = 0;
  logic [3:0] endpt_i = 0;
  logic txact_i = 0, txpop_i = 0, txpktfin_i = 0;
  logic [7:0] txdat_o;
  logic txval_o, txcork_o, rxrdy_o, in_ready_o, out_valid_o, rx_overflow_o;
  logic [11:0] txdat_len_o;
  logic [7:0] rxdat_i = 0, in_data_i = 0, out_data_o;
  logic rxval_i = 0, rxact_i = 0, rxpktval_i = 0, in_valid_i = 0, out_ready_i = 0;
  int total = 0, passed = 0;
  bq_t in_q, out_q;
  bit ovf_m = 0, hs = 0;
  vec_t vt [6];

  always #5 clk_i = ~clk_i;

  usb_bulk_ep_fifo dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .usbrst_i(usbrst_i), .highspeed_i(highspeed_i),
    .endpt_i(endpt_i), .txact_i(txact_i), .txpop_i(txpop_i), .txpktfin_i(txpktfin_i),
    .txdat_o(txdat_o), .txval_o(txval_o), .txdat_len_o(txdat_len_o), .txcork_o(txcork_o),
    .rxdat_i(rxdat_i), .rxval_i(rxval_i), .rxact_i(rxact_i), .rxpktval_i(rxpktval_i),
    .rxrdy_o(rxrdy_o), .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rx_overflow_o(rx_overflow_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  function automatic int maxpkt();
    return hs ? 512 : 64;
  endfunction

  task automatic set_hs(input bit b);
    hs = b;
    highspeed_i = b;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txcork"}, txcork_o, 1);
    chk({tag, "_txval"}, txval_o, 0);
    chk({tag, "_txlen"}, txdat_len_o, 0);
    chk({tag, "_txdat"}, txdat_o, 0);
    chk({tag, "_rxrdy"}, rxrdy_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_ovf"}, rx_overflow_o, 0);
  endtask

  task automatic do_usbrst;
    usbrst_i = 1;
    #1;
    chk("usbrst_txcork", txcork_o, 1);
    chk("usbrst_in_ready", in_ready_o, 0);
    chk("usbrst_out_valid", out_valid_o, 0);
    tick;
    usbrst_i = 0;
    in_q.delete();
    out_q.delete();
    ovf_m = 0;
    tick;
    chk("after_usbrst_ovf", rx_overflow_o, 0);
    chk("after_usbrst_out_valid", out_valid_o, 0);
    chk("after_usbrst_txcork", txcork_o, 1);
    chk("after_usbrst_in_ready", in_ready_o, 1);
    chk("after_usbrst_rxrdy", rxrdy_o, 1);
  endtask

  task automatic user_write(input int n, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
      chk("in_ready", in_ready_o, in_q.size() < DEPTH);
      in_valid_i = 1;
      in_data_i = v;
      tick;
      in_q.push_back(v);
    end
    in_valid_i = 0;
  endtask

  task automatic in_packet(input int ep, input int npop, input bit fin);
    int len;
    bit hit;
    len = in_q.size() < maxpkt() ? in_q.size() : maxpkt();
    hit = ep == 1 && len != 0;
    if (npop > len) npop = len;
    txact_i = 1;
    endpt_i = 4'(ep);
    tick;
    if (hit) begin
      chk("txdat_len", txdat_len_o, len);
      chk("txval_active", txval_o, 1);
    end else chk("txcork_ignored", txcork_o, in_q.size() == 0);
    for (int k = 0; k < npop; k++) begin
      if (hit) chk("txdat", txdat_o, in_q[k]);
      txpop_i = 1;
      tick;
    end
    txpop_i = 0;
    if (fin) begin
      txpktfin_i = 1;
      tick;
      txpktfin_i = 0;
    end
    txact_i = 0;
    tick;
    tick;
    if (hit && fin) repeat (npop) void'(in_q.pop_front());
    chk("txcork_idle", txcork_o, in_q.size() == 0);
  endtask

  task automatic out_packet(input int ep, input bq_t d, input bit pv);
    rxact_i = 1;
    endpt_i = 4'(ep);
    tick;
    foreach (d[i]) begin
      rxval_i = 1;
      rxdat_i = d[i];
      tick;
    end
    rxval_i = 0;
    if (pv) begin
      rxpktval_i = 1;
      tick;
      rxpktval_i = 0;
    end
    rxact_i = 0;
    tick;
    tick;
    if (ep == 1) begin
      if (d.size() > DEPTH - out_q.size()) ovf_m = 1;
      else if (pv) foreach (d[i]) out_q.push_back(d[i]);
    end
    chk("rx_overflow", rx_overflow_o, ovf_m);
    chk("rxrdy_pkt", rxrdy_o, (DEPTH - out_q.size()) >= maxpkt());
  endtask

  function automatic bq_t mk_bytes(input int n, input bit rnd, input logic [7:0] base);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(rnd ? 8'($urandom_range(0, 255)) : base + 8'(i));
    return q;
  endfunction

  task automatic drain(input int n);
    int f;
    if (n > out_q.size()) n = out_q.size();
    out_ready_i = 1;
    for (int k = 0; k < n; k++) begin
      chk("out_valid", out_valid_o, 1);
      chk("out_data", out_data_o, out_q[0]);
      f = DEPTH - out_q.size();
      tick;
      void'(out_q.pop_front());
      chk("rxrdy_drain", rxrdy_o, f >= maxpkt());
    end
    out_ready_i = 0;
    chk("out_valid_end", out_valid_o, out_q.size() != 0);
  endtask

  initial begin
    vt[0] = '{0, 100, 1, 64, 0};
    vt[1] = '{1, 100, 1, 100, 0};
    vt[2] = '{1, 600, 1, 512, 0};
    vt[3] = '{0, 10, 1, 10, 0};
    vt[4] = '{0, 0, 1, 0, 1};
    vt[5] = '{1, 50, 2, 0, 0};
    #2 rst_n_i = 0;
    repeat (3) tick;
    chk_reset("por");
    rst_n_i = 1;
    #1;
    chk("in_ready_pre", in_ready_o, 0);
    tick;
    chk("in_ready_post", in_ready_o, 1);
    chk("rxrdy_post", rxrdy_o, 1);

    foreach (vt[i]) begin
      do_usbrst();
      set_hs(vt[i].hs);
      user_write(vt[i].n, 1);
      txact_i = 1;
      endpt_i = 4'(vt[i].ep);
      tick;
      chk($sformatf("vec%0d_len", i), txdat_len_o, vt[i].len);
      chk($sformatf("vec%0d_cork", i), txcork_o, 32'(vt[i].cork));
      txact_i = 0;
      tick;
      tick;
    end
    do_usbrst();

    set_hs(0);
    user_write(100, 0);
    in_packet(1, 64, 1);
    in_packet(1, 100, 1);
    chk("in_empty_cork", txcork_o, 1);

    set_hs(1);
    user_write(40, 1);
    in_packet(1, 10, 0);
    in_packet(1, 40, 1);

    user_write(30, 1);
    in_packet(2, 5, 1);
    in_packet(1, 30, 1);

    do_usbrst();
    user_write(DEPTH, 1);
    chk("in_full", in_ready_o, 0);
    in_packet(1, 512, 1);
    chk("in_not_full", in_ready_o, 1);
    do_usbrst();

    set_hs(0);
    out_packet(1, mk_bytes(64, 0, 8'hA0), 1);
    drain(64);
    out_packet(1, mk_bytes(64, 1, 0), 0);
    chk("out_no_commit", out_valid_o, 0);

    set_hs(1);
    out_packet(1, mk_bytes(512, 1, 0), 1);
    out_packet(1, mk_bytes(88, 1, 0), 1);
    chk("rxrdy_600", rxrdy_o, 0);
    drain(100);
    chk("rxrdy_500", rxrdy_o, 1);
    drain(DEPTH);

    out_packet(1, mk_bytes(512, 1, 0), 1);
    out_packet(1, mk_bytes(12, 1, 0), 1);
    out_packet(1, mk_bytes(600, 1, 0), 1);
    chk("overflow_flag", rx_overflow_o, 1);
    drain(DEPTH);
    out_packet(1, mk_bytes(10, 1, 0), 1);
    user_write(10, 1);
    do_usbrst();

    set_hs(0);
    user_write(20, 1);
    txact_i = 1;
    endpt_i = 1;
    tick;
    txpop_i = 1;
    repeat (3) tick;
    rst_n_i = 0;
    #1;
    chk_reset("midpkt");
    txpop_i = 0;
    txact_i = 0;
    in_q.delete();
    out_q.delete();
    ovf_m = 0;
    tick;
    rst_n_i = 1;
    tick;
    tick;
    chk("post_rst_cork", txcork_o, 1);

    repeat (25) begin
      int n;
      set_hs(1'($urandom_range(0, 1)));
      n = $urandom_range(0, 150);
      if (in_q.size() + n > DEPTH) n = 0;
      user_write(n, 1);
      in_packet($urandom_range(0, 3) == 0 ? 2 : 1, $urandom_range(0, 600), $urandom_range(0, 3) != 0);
      out_packet($urandom_range(0, 3) == 0 ? 2 : 1, mk_bytes($urandom_range(0, 200), 1, 0), $urandom_range(0, 3) != 0);
      drain($urandom_range(0, out_q.size()));
    end
    drain(DEPTH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
